// File: rtl/axi_master_aw_queue_if.sv
// ---------------------------------------------------------------------------
// axi_master_aw_queue_if
//
// Purpose:
//   Groups every handshake and bus signal of the AXI4 write-address issuer:
//   the user request port, the AXI AW channel, the observed B handshake,
//   the burst-length hand-off to the W-channel block and the status outputs.
//
// Modports:
//   master : view of the issuer itself (drives AW, tx_awlen, status)
//   slave  : view of the surroundings (user side, interconnect, W/B blocks)
//
// Signal summary:
//   write_addr_valid/ready, awaddr, awlen, awsize, awburst  user request port
//   m_axi_aw*                                               AXI AW channel
//   m_axi_bvalid, m_axi_bready                              observed B handshake
//   tx_awlen, tx_awlen_valid, tx_awlen_ready                burst length to W block
//   outstanding, err_4k                                     status
// ---------------------------------------------------------------------------
interface axi_master_aw_queue_if #(
   parameter int ID_W   = 12,
   parameter int ADDR_W = 32
);
   logic              write_addr_valid;
   logic              write_addr_ready;
   logic [ADDR_W-1:0] awaddr;
   logic [7:0]        awlen;
   logic [2:0]        awsize;
   logic [1:0]        awburst;

   logic [ID_W-1:0]   m_axi_awid;
   logic [ADDR_W-1:0] m_axi_awaddr;
   logic [7:0]        m_axi_awlen;
   logic [2:0]        m_axi_awsize;
   logic [1:0]        m_axi_awburst;
   logic              m_axi_awlock;
   logic [3:0]        m_axi_awcache;
   logic [2:0]        m_axi_awprot;
   logic [3:0]        m_axi_awqos;
   logic              m_axi_awvalid;
   logic              m_axi_awready;

   logic              m_axi_bvalid;
   logic              m_axi_bready;

   logic [7:0]        tx_awlen;
   logic              tx_awlen_valid;
   logic              tx_awlen_ready;

   logic [7:0]        outstanding;
   logic              err_4k;

   modport master (
      input  write_addr_valid, awaddr, awlen, awsize, awburst,
      output write_addr_ready,
      output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
      output m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
      input  m_axi_awready,
      input  m_axi_bvalid, m_axi_bready,
      output tx_awlen, tx_awlen_valid,
      input  tx_awlen_ready,
      output outstanding, err_4k
   );

   modport slave (
      output write_addr_valid, awaddr, awlen, awsize, awburst,
      input  write_addr_ready,
      input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
      input  m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
      output m_axi_awready,
      output m_axi_bvalid, m_axi_bready,
      input  tx_awlen, tx_awlen_valid,
      output tx_awlen_ready,
      input  outstanding, err_4k
   );
endinterface

// File: rtl/axi_master_aw_queue.sv
// ---------------------------------------------------------------------------
// axi_master_aw_queue
//
// Purpose:
//   AXI4 master write-address issuer. User write-address requests are queued
//   in a DEPTH-entry FIFO, issued one at a time on the AW channel with stable
//   valid/payload, and each issued burst length is handed to the W-channel
//   block. The number of bursts whose response is still pending is capped
//   at MAX_OUT.
//
// Ports:
//   clk            rising-edge clock
//   m_axi_aresetn  asynchronous active-low reset
//   bus            axi_master_aw_queue_if.master (user port, AW channel,
//                  observed B handshake, tx_awlen hand-off, status)
//
// Parameters:
//   ID_W, ADDR_W   AWID / address widths (must match the interface)
//   DEPTH          request FIFO entries, power of 2, >= 2
//   MAX_OUT        maximum outstanding bursts, 1..255
//   AW_ID          constant AWID value
//
// Configuration:
//   AXI_AW_4K_CHECK_EN  when defined, INCR requests that would cross a 4 KB
//                       boundary are consumed but dropped, pulsing err_4k.
//                       When undefined every request is queued, err_4k = 0.
// ---------------------------------------------------------------------------
module axi_master_aw_queue #(
   parameter int          ID_W    = 12,
   parameter int          ADDR_W  = 32,
   parameter int          DEPTH   = 4,
   parameter int          MAX_OUT = 8,
   parameter int unsigned AW_ID   = 0
) (
   input  logic                  clk,
   input  logic                  m_axi_aresetn,
   axi_master_aw_queue_if.master bus
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        len;
      logic [2:0]        size;
      logic [1:0]        burst;
   } req_t;

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      LEN
   } state_t;

   req_t              mem_q [DEPTH];
   req_t              pushReq;
   req_t              headReq;
   logic [PTR_W:0]    wrPtr_q, wrPtr_d;
   logic [PTR_W:0]    rdPtr_q, rdPtr_d;
   logic [7:0]        outstanding_q, outstanding_d;

   state_t            state_q;
   logic [ADDR_W-1:0] awAddr_q;
   logic [7:0]        awLen_q;
   logic [2:0]        awSize_q;
   logic [1:0]        awBurst_q;
   logic              awValid_q;
   logic [7:0]        txAwlen_q;
   logic              txValid_q;

   logic              fifoEmpty;
   logic              fifoFull;
   logic              accept;
   logic              reject;
   logic              push;
   logic              pop;
   logic              awHs;
   logic              bHs;
   logic              outInc;
   logic              outDec;

   // Full/empty come from the extra pointer MSB: equal index with differing
   // wrap bit means full. Ready is forced low while reset is held.
   assign fifoEmpty = (wrPtr_q == rdPtr_q);
   assign fifoFull  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                      (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);

   assign bus.write_addr_ready = m_axi_aresetn & ~fifoFull;
   assign accept               = bus.write_addr_valid & bus.write_addr_ready;

`ifdef AXI_AW_4K_CHECK_EN
   // Last byte offset of the burst within its 4 KB page, in 16 bits so the
   // largest possible burst (256 beats of 128 bytes) cannot overflow.
   logic [15:0] burstEnd;
   assign burstEnd = 16'(bus.awaddr[11:0])
                   + ((16'(bus.awlen) + 16'd1) << bus.awsize)
                   - 16'd1;
   assign reject   = (bus.awburst == 2'b01) && (burstEnd > 16'd4095);
`else
   assign reject   = 1'b0;
`endif

   // A rejected request is still handshaken so the user side never stalls.
   assign push       = accept & ~reject;
   assign bus.err_4k = accept & reject;

   // The FSM can only take a new entry from IDLE, and only while another
   // burst would not exceed the outstanding cap.
   assign pop  = (state_q == IDLE) && !fifoEmpty && (outstanding_q < 8'(MAX_OUT));
   assign awHs = awValid_q & bus.m_axi_awready;
   assign bHs  = bus.m_axi_bvalid & bus.m_axi_bready;

   assign pushReq = '{addr: bus.awaddr, len: bus.awlen, size: bus.awsize, burst: bus.awburst};
   assign headReq = mem_q[rdPtr_q[PTR_W-1:0]];

   // Next-state for the FIFO pointers and the outstanding-burst counter.
   // The counter saturates at both ends, so a stray B response at zero is
   // ignored and an AW plus B in the same cycle cancel out.
   always_comb begin
      wrPtr_d       = push ? wrPtr_q + (PTR_W+1)'(1) : wrPtr_q;
      rdPtr_d       = pop  ? rdPtr_q + (PTR_W+1)'(1) : rdPtr_q;
      outInc        = awHs && (outstanding_q != 8'(MAX_OUT));
      outDec        = bHs  && (outstanding_q != 8'd0);
      outstanding_d = outstanding_q;
      if (outInc && !outDec) begin
         outstanding_d = outstanding_q + 8'd1;
      end else if (outDec && !outInc) begin
         outstanding_d = outstanding_q - 8'd1;
      end
   end

   // Pointer and counter registers; a reset empties the FIFO, which is how
   // queued requests get discarded.
   always_ff @(posedge clk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         wrPtr_q       <= '0;
         rdPtr_q       <= '0;
         outstanding_q <= '0;
      end else begin
         wrPtr_q       <= wrPtr_d;
         rdPtr_q       <= rdPtr_d;
         outstanding_q <= outstanding_d;
      end
   end

   // FIFO storage carries no reset; its contents only matter behind the
   // pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wrPtr_q[PTR_W-1:0]] <= pushReq;
      end
   end

   // Issue FSM with registered AW and tx_awlen outputs. Payload registers
   // are loaded only on pop, so they stay stable for the whole ADDR wait.
   always_ff @(posedge clk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         state_q   <= IDLE;
         awAddr_q  <= '0;
         awLen_q   <= '0;
         awSize_q  <= '0;
         awBurst_q <= '0;
         awValid_q <= 1'b0;
         txAwlen_q <= '0;
         txValid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pop) begin
                  awAddr_q  <= headReq.addr;
                  awLen_q   <= headReq.len;
                  awSize_q  <= headReq.size;
                  awBurst_q <= headReq.burst;
                  awValid_q <= 1'b1;
                  state_q   <= ADDR;
               end
            end
            ADDR: begin
               if (bus.m_axi_awready) begin
                  awValid_q <= 1'b0;
                  txAwlen_q <= awLen_q;
                  txValid_q <= 1'b1;
                  state_q   <= LEN;
               end
            end
            LEN: begin
               if (bus.tx_awlen_ready) begin
                  txValid_q <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.m_axi_awid     = ID_W'(AW_ID);
   assign bus.m_axi_awaddr   = awAddr_q;
   assign bus.m_axi_awlen    = awLen_q;
   assign bus.m_axi_awsize   = awSize_q;
   assign bus.m_axi_awburst  = awBurst_q;
   assign bus.m_axi_awlock   = 1'b0;
   assign bus.m_axi_awcache  = 4'b0011;
   assign bus.m_axi_awprot   = 3'b000;
   assign bus.m_axi_awqos    = 4'b0000;
   assign bus.m_axi_awvalid  = awValid_q;
   assign bus.tx_awlen       = txAwlen_q;
   assign bus.tx_awlen_valid = txValid_q;
   assign bus.outstanding    = outstanding_q;

endmodule

// File: tb/tb_axi_master_aw_queue.sv
// ---------------------------------------------------------------------------
// tb_axi_master_aw_queue
//
// Bench for axi_master_aw_queue (DEPTH=4, MAX_OUT=2, AW_ID=5). Requests push
// their expected AW payload and tx_awlen into queues; a monitor on the
// opposite clock edge pops and compares whenever the DUT completes an AW or
// tx_awlen handshake, and also checks AW stability while stalled.
// ---------------------------------------------------------------------------
module tb_axi_master_aw_queue;

   localparam int ID_W    = 12;
   localparam int ADDR_W  = 32;
   localparam int DEPTH   = 4;
   localparam int MAX_OUT = 2;
   localparam int AW_ID   = 5;

   localparam int SEL_OUT   = 0;
   localparam int SEL_AWV   = 1;
   localparam int SEL_READY = 2;

`ifdef AXI_AW_4K_CHECK_EN
   localparam bit EXP_REJECT = 1'b1;
`else
   localparam bit EXP_REJECT = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;

   int vectors     = 0;
   int miscompares = 0;

   exp_t       awQ [$];
   logic [7:0] lenQ [$];

   always #5 clk = ~clk;

   axi_master_aw_queue_if #(.ID_W(ID_W), .ADDR_W(ADDR_W)) bus ();

   axi_master_aw_queue #(
      .ID_W   (ID_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .MAX_OUT(MAX_OUT),
      .AW_ID  (AW_ID)
   ) dut (
      .clk          (clk),
      .m_axi_aresetn(rst_n),
      .bus          (bus)
   );

   // Single comparison point: every check steps the same two counters.
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   function automatic logic [7:0] sample(input int sel);
      case (sel)
         SEL_OUT: return bus.outstanding;
         SEL_AWV: return 8'(bus.m_axi_awvalid);
         default: return 8'(bus.write_addr_ready);
      endcase
   endfunction

   // Called at posedge+1; returns at posedge+1 of the accepting edge.
   task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst,
                                input bit expReject);
      bit done = 1'b0;
      bus.write_addr_valid = 1'b1;
      bus.awaddr  = addr;
      bus.awlen   = len;
      bus.awsize  = size;
      bus.awburst = burst;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (bus.write_addr_ready) begin
            checkOutput("err_4k", 64'(bus.err_4k), 64'(expReject));
            if (!expReject) begin
               awQ.push_back('{addr: addr, len: len, size: size, burst: burst});
               lenQ.push_back(len);
            end
            done = 1'b1;
         end
      end
      if (!done) checkOutput("push_timeout", 64'(0), 64'(1));
      @(posedge clk); #1;
      bus.write_addr_valid = 1'b0;
   endtask

   // Bounded wait for a DUT output to reach a value; the last sample is the
   // comparison, so an expired bound reports as a FAIL.
   task automatic waitSig(input int sel, input logic [7:0] target, input string name);
      logic [7:0] v = '0;
      bit hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
         @(negedge clk);
         v   = sample(sel);
         hit = (v == target);
      end
      checkOutput(name, 64'(v), 64'(target));
      @(posedge clk); #1;
   endtask

   task automatic sendB();
      bus.m_axi_bvalid = 1'b1;
      @(posedge clk); #1;
      bus.m_axi_bvalid = 1'b0;
   endtask

   // Monitor / scoreboard.
   exp_t        e;
   logic        prevPending = 1'b0;
   logic [31:0] prevAddr;
   logic [7:0]  prevLen;
   logic [7:0]  expLen;

   always @(negedge clk) begin
      if (!rst_n) begin
         prevPending = 1'b0;
      end else begin
         if (prevPending) begin
            checkOutput("awvalid_held", 64'(bus.m_axi_awvalid), 64'(1));
            checkOutput("awaddr_stable", 64'(bus.m_axi_awaddr), 64'(prevAddr));
            checkOutput("awlen_stable", 64'(bus.m_axi_awlen), 64'(prevLen));
         end
         if (bus.m_axi_awvalid && bus.m_axi_awready) begin
            if (awQ.size() == 0) begin
               checkOutput("unexpected_aw", 64'(bus.m_axi_awaddr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               e = awQ.pop_front();
               checkOutput("awaddr", 64'(bus.m_axi_awaddr), 64'(e.addr));
               checkOutput("awlen", 64'(bus.m_axi_awlen), 64'(e.len));
               checkOutput("awsize", 64'(bus.m_axi_awsize), 64'(e.size));
               checkOutput("awburst", 64'(bus.m_axi_awburst), 64'(e.burst));
               checkOutput("awid", 64'(bus.m_axi_awid), 64'(AW_ID));
               checkOutput("awcache", 64'(bus.m_axi_awcache), 64'(4'b0011));
               checkOutput("awlock_prot_qos", 64'({bus.m_axi_awlock, bus.m_axi_awprot, bus.m_axi_awqos}), 64'(0));
            end
         end
         prevPending = bus.m_axi_awvalid && !bus.m_axi_awready;
         prevAddr    = bus.m_axi_awaddr;
         prevLen     = bus.m_axi_awlen;
         if (bus.tx_awlen_valid && bus.tx_awlen_ready) begin
            if (lenQ.size() == 0) begin
               checkOutput("unexpected_tx_awlen", 64'(bus.tx_awlen), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               expLen = lenQ.pop_front();
               checkOutput("tx_awlen", 64'(bus.tx_awlen), 64'(expLen));
            end
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n                = 1'b0;
      bus.write_addr_valid = 1'b0;
      bus.awaddr           = '0;
      bus.awlen            = '0;
      bus.awsize           = '0;
      bus.awburst          = '0;
      bus.m_axi_awready    = 1'b0;
      bus.m_axi_bvalid     = 1'b0;
      bus.m_axi_bready     = 1'b1;
      bus.tx_awlen_ready   = 1'b1;

      // Reset state.
      #12;
      checkOutput("rst_ready", 64'(bus.write_addr_ready), 64'(0));
      checkOutput("rst_awvalid", 64'(bus.m_axi_awvalid), 64'(0));
      checkOutput("rst_txvalid", 64'(bus.tx_awlen_valid), 64'(0));
      checkOutput("rst_outstanding", 64'(bus.outstanding), 64'(0));
      checkOutput("rst_awcache", 64'(bus.m_axi_awcache), 64'(4'b0011));
      checkOutput("rst_awid", 64'(bus.m_axi_awid), 64'(AW_ID));
      checkOutput("rst_err_4k", 64'(bus.err_4k), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Single burst and first-request latency.
      bus.m_axi_awready = 1'b1;
      applyStimulus(32'h1000, 8'd3, 3'd3, 2'b01, 1'b0);
      @(negedge clk);
      checkOutput("lat_not_yet", 64'(bus.m_axi_awvalid), 64'(0));
      @(negedge clk);
      checkOutput("lat_awvalid", 64'(bus.m_axi_awvalid), 64'(1));
      @(negedge clk);
      checkOutput("single_awvalid_low", 64'(bus.m_axi_awvalid), 64'(0));
      checkOutput("single_txvalid", 64'(bus.tx_awlen_valid), 64'(1));
      checkOutput("single_tx_awlen", 64'(bus.tx_awlen), 64'(3));
      checkOutput("single_outstanding", 64'(bus.outstanding), 64'(1));
      @(negedge clk);
      checkOutput("single_txvalid_drop", 64'(bus.tx_awlen_valid), 64'(0));
      @(posedge clk); #1;
      sendB();
      waitSig(SEL_OUT, 8'd0, "b_decrement");
      sendB();
      @(negedge clk);
      checkOutput("stray_b", 64'(bus.outstanding), 64'(0));
      @(posedge clk); #1;

      // AW backpressure: payload and valid held until awready.
      bus.m_axi_awready = 1'b0;
      applyStimulus(32'h2000, 8'd7, 3'd2, 2'b01, 1'b0);
      waitSig(SEL_AWV, 8'd1, "bp_awvalid");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("bp_awvalid_hold", 64'(bus.m_axi_awvalid), 64'(1));
         checkOutput("bp_awaddr", 64'(bus.m_axi_awaddr), 64'(32'h2000));
         checkOutput("bp_awlen", 64'(bus.m_axi_awlen), 64'(7));
      end
      @(posedge clk); #1;
      bus.m_axi_awready = 1'b1;
      waitSig(SEL_OUT, 8'd1, "bp_outstanding");
      sendB();
      waitSig(SEL_OUT, 8'd0, "bp_drain");

      // FIFO full and outstanding cap (MAX_OUT=2).
      bus.m_axi_awready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(32'h3000 + 32'(i) * 32'h100, 8'(i), 3'd2, 2'b01, 1'b0);
      end
      @(negedge clk);
      checkOutput("full_ready_low", 64'(bus.write_addr_ready), 64'(0));
      @(negedge clk);
      checkOutput("full_ready_still_low", 64'(bus.write_addr_ready), 64'(0));
      checkOutput("full_awvalid_held", 64'(bus.m_axi_awvalid), 64'(1));
      @(posedge clk); #1;
      bus.m_axi_awready = 1'b1;
      waitSig(SEL_READY, 8'd1, "full_ready_back");
      waitSig(SEL_OUT, 8'd2, "cap_two");
      bus.m_axi_awready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("cap_no_awvalid", 64'(bus.m_axi_awvalid), 64'(0));
         checkOutput("cap_outstanding", 64'(bus.outstanding), 64'(2));
      end
      @(posedge clk); #1;
      sendB();
      waitSig(SEL_AWV, 8'd1, "cap_release");
      @(negedge clk);
      checkOutput("pre_sim_outstanding", 64'(bus.outstanding), 64'(1));
      @(posedge clk); #1;

      // Simultaneous AW and B handshake at outstanding=1.
      bus.m_axi_awready = 1'b1;
      bus.m_axi_bvalid  = 1'b1;
      @(posedge clk); #1;
      bus.m_axi_bvalid  = 1'b0;
      @(negedge clk);
      checkOutput("sim_aw_b", 64'(bus.outstanding), 64'(1));
      @(posedge clk); #1;
      waitSig(SEL_OUT, 8'd2, "req4_issued");
      sendB();
      waitSig(SEL_OUT, 8'd1, "req4_b");
      waitSig(SEL_OUT, 8'd2, "req5_issued");
      sendB();
      waitSig(SEL_OUT, 8'd1, "drain_one");
      sendB();
      waitSig(SEL_OUT, 8'd0, "drain_zero");
      @(negedge clk);
      checkOutput("drained_ready", 64'(bus.write_addr_ready), 64'(1));
      checkOutput("drained_awq", 64'(awQ.size()), 64'(0));
      @(posedge clk); #1;

      // 4 KB boundary: 0xFF0 + 32 bytes crosses, 0xFE0 + 32 bytes does not.
      applyStimulus(32'h0FF0, 8'd3, 3'd3, 2'b01, EXP_REJECT);
`ifdef AXI_AW_4K_CHECK_EN
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("k4_no_awvalid", 64'(bus.m_axi_awvalid), 64'(0));
      end
      @(posedge clk); #1;
`else
      waitSig(SEL_OUT, 8'd1, "k4_off_issued");
      sendB();
      waitSig(SEL_OUT, 8'd0, "k4_off_drain");
`endif
      applyStimulus(32'h0FE0, 8'd3, 3'd3, 2'b01, 1'b0);
      waitSig(SEL_OUT, 8'd1, "k4_ok_issued");
      sendB();
      waitSig(SEL_OUT, 8'd0, "k4_ok_drain");
      applyStimulus(32'h0FF0, 8'd3, 3'd3, 2'b10, 1'b0);
      waitSig(SEL_OUT, 8'd1, "k4_wrap_issued");
      sendB();
      waitSig(SEL_OUT, 8'd0, "k4_wrap_drain");

      // Reset mid-burst: outputs drop at once, queued request discarded.
      bus.m_axi_awready = 1'b0;
      applyStimulus(32'h5000, 8'd1, 3'd2, 2'b01, 1'b0);
      applyStimulus(32'h5100, 8'd2, 3'd2, 2'b01, 1'b0);
      waitSig(SEL_AWV, 8'd1, "rst_mid_awvalid");
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_awvalid_drop", 64'(bus.m_axi_awvalid), 64'(0));
      checkOutput("rst_mid_txvalid", 64'(bus.tx_awlen_valid), 64'(0));
      checkOutput("rst_mid_ready", 64'(bus.write_addr_ready), 64'(0));
      awQ.delete();
      lenQ.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.m_axi_awready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("rst_discard_awvalid", 64'(bus.m_axi_awvalid), 64'(0));
      end
      checkOutput("rst_after_ready", 64'(bus.write_addr_ready), 64'(1));
      checkOutput("final_lenq", 64'(lenQ.size()), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
